// File: rtl/lsu_axi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_axi_master_if
//  Description : AXI-lite bus bundle (AR/R/AW/W/B) with master/slave views.
//  Revision    : 1.0
// ============================================================================
interface lsu_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input  arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input  awready,
        output wdata, wstrb, wvalid, input  wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input  rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input  bready
    );
endinterface
`default_nettype wire

// File: rtl/lsu_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_axi_master
//  Description : Single-outstanding AXI-lite master turning LSU load/store
//                requests into AXI-lite transactions; all AXI outputs registered.
//  Revision    : 1.0
// ============================================================================
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic                clk,
    input  wire logic                rst_n,

    input  wire logic                req_valid_i,
    output logic                     req_ready_o,
    input  wire logic                req_we_i,
    input  wire logic [ADDR_W-1:0]   req_addr_i,
    input  wire logic [DATA_W-1:0]   req_wdata_i,
    input  wire logic [DATA_W/8-1:0] req_wstrb_i,

    output logic                     resp_valid_o,
    input  wire logic                resp_ready_i,
    output logic [DATA_W-1:0]        resp_rdata_o,
    output logic                     resp_err_o,

    lsu_axi_master_if.master         axi
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_RESP    = 3'd5
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                aw_pend_q;
    logic                w_pend_q;
    logic                bready_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;

    logic                w_aw_done;
    logic                w_wd_done;

    assign w_aw_done = aw_pend_q & axi.awready;
    assign w_wd_done = w_pend_q  & axi.wready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        wstrb_q <= req_wstrb_i;
                        if (req_we_i) begin
                            aw_pend_q <= 1'b1;
                            w_pend_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (axi.rvalid) begin
                        rready_q     <= 1'b0;
                        resp_rdata_q <= axi.rdata;
                        resp_err_q   <= (axi.rresp != 2'b00);
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_WR_REQ: begin
                    // AW and W complete independently; leave once neither is outstanding.
                    if (w_aw_done) aw_pend_q <= 1'b0;
                    if (w_wd_done) w_pend_q  <= 1'b0;
                    if ((!aw_pend_q || w_aw_done) && (!w_pend_q || w_wd_done)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= (axi.bresp != 2'b00);
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    aw_pend_q    <= 1'b0;
                    w_pend_q     <= 1'b0;
                    bready_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) && rst_n;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = addr_q;
    assign axi.awvalid = aw_pend_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = w_pend_q;
    assign axi.bready  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_axi_master
//  Description : Self-checking bench for lsu_axi_master with a cycle-driven
//                AXI-lite slave and a latency/response reference model.
//  Revision    : 1.0
// ============================================================================
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int checks = 0;
    int errors = 0;

    lsu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .axi          (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    endtask

    // One transaction: slave waits are counted from the cycle each channel may first act.
    // Expected latency: read 3+ar_d+r_d, write 3+max(aw_d,w_d)+b_d.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [31:0] rd, input logic [1:0] rsp,
                       input int ar_d, input int r_d, input int aw_d, input int w_d,
                       input int b_d, input int rr_d);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat, cyc, ar_c, aw_c, w_c, wr_c, rr_n;
        bit          fin, ar_dn, r_dn, aw_dn, w_dn, wr_dn, b_dn, seen;
        logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_err;
        logic [31:0] p_rdata;

        exp_data = we ? 32'h0 : rd;
        exp_err  = (rsp != 2'b00);
        exp_lat  = we ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
        {fin, ar_dn, r_dn, aw_dn, w_dn, wr_dn, b_dn, seen} = '0;
        {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_err} = '0;
        {ar_c, aw_c, w_c, wr_c, rr_n} = '0;
        p_rdata = '0;

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        cyc = 1;
        while (!fin && cyc < 100) begin
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            chk("ready_valid_overlap",
                {31'b0, (axi.rready | axi.bready) & (axi.arvalid | axi.awvalid)}, 32'd0);
            chk("wrong_channel", {31'b0, we ? (axi.arvalid | axi.rready)
                                            : (axi.awvalid | axi.wvalid | axi.bready)}, 32'd0);
            if (cyc == 1)
                chk("valid_cycle1", {30'b0, axi.awvalid, axi.wvalid | axi.arvalid},
                    we ? 32'd3 : 32'd1);
            if (p_arv && !p_arr) chk("ar_hold", {31'b0, axi.arvalid}, 32'd1);
            if (p_awv && !p_awr) chk("aw_hold", {31'b0, axi.awvalid}, 32'd1);
            if (p_wv  && !p_wr)  chk("w_hold",  {31'b0, axi.wvalid},  32'd1);
            if (ar_dn) chk("ar_drop", {31'b0, axi.arvalid}, 32'd0);
            if (aw_dn) chk("aw_drop", {31'b0, axi.awvalid}, 32'd0);
            if (w_dn)  chk("w_drop",  {31'b0, axi.wvalid},  32'd0);
            if (axi.arvalid) chk("araddr", axi.araddr, addr);
            if (axi.awvalid) chk("awaddr", axi.awaddr, addr);
            if (axi.wvalid) begin
                chk("wdata", axi.wdata, wd);
                chk("wstrb", {28'b0, axi.wstrb}, {28'b0, strb});
            end

            axi.arready = !we && !ar_dn && (cyc >= 1 + ar_d);
            axi.rvalid  = ar_dn && !r_dn && (cyc >= ar_c + 1 + r_d);
            axi.rdata   = axi.rvalid ? rd : $urandom;
            axi.rresp   = rsp;
            axi.awready = we && !aw_dn && (cyc >= 1 + aw_d);
            axi.wready  = we && !w_dn  && (cyc >= 1 + w_d);
            axi.bvalid  = wr_dn && !b_dn && (cyc >= wr_c + 1 + b_d);
            axi.bresp   = rsp;

            if (resp_valid) begin
                if (!seen) begin
                    chk("resp_latency", cyc, exp_lat);
                    chk("resp_rdata", resp_rdata, exp_data);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
                    seen = 1'b1;
                end else begin
                    chk("resp_rdata_stable", resp_rdata, p_rdata);
                    chk("resp_err_stable", {31'b0, resp_err}, {31'b0, p_err});
                end
                resp_ready = (rr_n >= rr_d);
                rr_n++;
            end else begin
                resp_ready = 1'($urandom_range(0, 1));
            end

            if (axi.arvalid && axi.arready) begin ar_dn = 1'b1; ar_c = cyc; end
            if (axi.rvalid && axi.rready)   r_dn = 1'b1;
            if (axi.awvalid && axi.awready) begin aw_dn = 1'b1; aw_c = cyc; end
            if (axi.wvalid && axi.wready)   begin w_dn = 1'b1; w_c = cyc; end
            if (aw_dn && w_dn && !wr_dn) begin
                wr_dn = 1'b1;
                wr_c  = (aw_c > w_c) ? aw_c : w_c;
            end
            if (axi.bvalid && axi.bready) b_dn = 1'b1;
            if (resp_valid && resp_ready) fin = 1'b1;

            p_arv = axi.arvalid; p_arr = axi.arready;
            p_awv = axi.awvalid; p_awr = axi.awready;
            p_wv  = axi.wvalid;  p_wr  = axi.wready;
            p_rdata = resp_rdata; p_err = resp_err;
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("txn_timeout", {31'b0, fin}, 32'd1);
        chk("slave_handshake", {31'b0, we ? b_dn : r_dn}, 32'd1);
        slave_idle();
        resp_ready = 1'b0;
        chk("resp_drop", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        slave_idle();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_valids", {26'b0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready,
                           axi.bready, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Zero-wait load
        txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0);
        // Store: awready delayed 3, wready immediate
        txn(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 32'h0, 2'b00, 0, 0, 3, 0, 0, 0);
        // Error responses
        txn(1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, 1, 2, 0, 0, 0, 0);
        txn(1'b1, 32'h0000_1008, 32'hA5A5_5A5A, 4'b1111, 32'h0, 2'b11, 0, 0, 1, 2, 1, 0);
        // Core stalls the response for 5 cycles
        txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0BAD_CAFE, 2'b00, 0, 0, 0, 0, 0, 5);

        // Reset while waiting in RD_DATA
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; axi.arready = 1'b1;
        @(posedge clk); @(negedge clk);
        axi.arready = 1'b0;
        chk("mid_rst_rready", {31'b0, axi.rready}, 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("mid_rst_valids", {26'b0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready,
                               axi.bready, resp_valid}, 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        #1 chk("mid_rst_idle", {31'b0, req_ready}, 32'd1);
        axi.rvalid = 1'b1; axi.rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("stale_rvalid_ignored", {30'b0, resp_valid, axi.rready}, 32'd0);
        end
        slave_idle();

        // Randomized back-to-back loads and stores with slave stalls
        for (int n = 0; n < 30; n++) begin
            bit we;
            we = (n % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            txn(we, $urandom, $urandom, 4'($urandom), $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
